byte_sequencer: RTL and testbench

BYTE_SEQUENCER -- requirements
Module: byte_sequencer

---
 rtl/byte_sequencer.sv | 107 ++++++++++
 tb/tb_byte_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/byte_sequencer.sv
// Byte-to-word load sequencer: packs accepted bytes little-endian into a
// downstream 32-bit word buffer, one word at a time, for a burst of 2**IDX_W words.
module byte_sequencer #(
   parameter int IDX_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [7:0]       i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [7:0]       o_byte,
   output logic [1:0]       o_address,
   output logic             o_wr,
   output logic             o_word_valid,
   output logic [IDX_W-1:0] o_word_index,
   input  logic             i_word_ack,
   output logic             o_done
);

   typedef enum logic [1:0] {IDLE, FILL, HOLD, DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       lane_q, lane_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [7:0]       byte_q, byte_d;
   logic [1:0]       addr_q, addr_d;
   logic             wr_q, wr_d;
   logic             wv_q, wv_d;

   logic accept, ack, last_word, start_ok;

   assign accept    = i_valid & o_ready;
   // An ack only counts once the consumer has actually been shown the word.
   assign ack       = i_word_ack & wv_q & (state_q == HOLD);
   assign last_word = &idx_q;
   assign start_ok  = i_start & ((state_q == IDLE) | (state_q == DONE));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (i_start) state_d = FILL;
         FILL:       if (accept && lane_q == 2'd3) state_d = HOLD;
         HOLD:       if (ack) state_d = last_word ? DONE : FILL;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state_q == FILL);
      o_done  = (state_q == DONE);
   end

   always_comb begin
      lane_d = lane_q;
      idx_d  = idx_q;
      byte_d = byte_q;
      addr_d = addr_q;
      wr_d   = 1'b0;
      // Rises the cycle after the lane-3 strobe, drops on the accepting ack.
      wv_d   = (state_q == HOLD) & ~ack;
      if (accept) begin
         byte_d = i_data;
         addr_d = lane_q;
         wr_d   = 1'b1;
         lane_d = lane_q + 2'd1;
      end
      if (start_ok) begin
         lane_d = '0;
         idx_d  = '0;
      end
      if (ack && !last_word) begin
         idx_d  = idx_q + IDX_W'(1);
         lane_d = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lane_q <= '0;
         idx_q  <= '0;
         byte_q <= '0;
         addr_q <= '0;
         wr_q   <= 1'b0;
         wv_q   <= 1'b0;
      end else begin
         lane_q <= lane_d;
         idx_q  <= idx_d;
         byte_q <= byte_d;
         addr_q <= addr_d;
         wr_q   <= wr_d;
         wv_q   <= wv_d;
      end
   end

   assign o_byte       = byte_q;
   assign o_address    = addr_q;
   assign o_wr         = wr_q;
   assign o_word_valid = wv_q;
   assign o_word_index = idx_q;

endmodule

// File: tb/tb_byte_sequencer.sv
// Directed bench for byte_sequencer with a 4-word burst (IDX_W=2).
module tb_byte_sequencer;
   localparam int IDX_W = 2;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_start = 1'b0;
   logic [7:0]       i_data = 8'h00;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [7:0]       o_byte;
   logic [1:0]       o_address;
   logic             o_wr;
   logic             o_word_valid;
   logic [IDX_W-1:0] o_word_index;
   logic             i_word_ack = 1'b0;
   logic             o_done;

   int n_vec = 0;
   int n_err = 0;

   byte_sequencer #(.IDX_W(IDX_W)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
      .i_valid(i_valid), .o_ready(o_ready), .o_byte(o_byte),
      .o_address(o_address), .o_wr(o_wr), .o_word_valid(o_word_valid),
      .o_word_index(o_word_index), .i_word_ack(i_word_ack), .o_done(o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".ready"}, 32'(o_ready), 0);
      chk({tag, ".byte"},  32'(o_byte), 0);
      chk({tag, ".addr"},  32'(o_address), 0);
      chk({tag, ".wr"},    32'(o_wr), 0);
      chk({tag, ".wv"},    32'(o_word_valid), 0);
      chk({tag, ".idx"},   32'(o_word_index), 0);
      chk({tag, ".done"},  32'(o_done), 0);
   endtask

   // Send one byte and check its strobe on the following cycle.
   task automatic put(input logic [7:0] d, input logic [1:0] lane);
      i_data = d; i_valid = 1'b1;
      cyc();
      chk("put.wr",   32'(o_wr), 1);
      chk("put.byte", 32'(o_byte), 32'(d));
      chk("put.addr", 32'(o_address), 32'(lane));
   endtask

   initial begin
      #2;
      chk_all_zero("reset");
      @(negedge i_clk); i_rst = 1'b0;

      // Word 0 back-to-back
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("start.ready", 32'(o_ready), 1);
      chk("start.idx",   32'(o_word_index), 0);
      put(8'h11, 2'd0);
      put(8'h22, 2'd1);
      put(8'h33, 2'd2);
      i_data = 8'h44;
      cyc();
      chk("w0.l3.wr",   32'(o_wr), 1);
      chk("w0.l3.byte", 32'(o_byte), 32'h44);
      chk("w0.l3.addr", 32'(o_address), 3);
      chk("w0.l3.rdy",  32'(o_ready), 0);
      chk("w0.l3.wv",   32'(o_word_valid), 0);

      // Hold five cycles with traffic offered and no ack
      i_data = 8'hFF; i_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("hold.wv",   32'(o_word_valid), 1);
         chk("hold.wr",   32'(o_wr), 0);
         chk("hold.rdy",  32'(o_ready), 0);
         chk("hold.idx",  32'(o_word_index), 0);
         chk("hold.byte", 32'(o_byte), 32'h44);
         chk("hold.addr", 32'(o_address), 3);
      end
      i_word_ack = 1'b1;
      cyc();
      i_word_ack = 1'b0; i_valid = 1'b0;
      chk("ack0.idx", 32'(o_word_index), 1);
      chk("ack0.rdy", 32'(o_ready), 1);
      chk("ack0.wv",  32'(o_word_valid), 0);

      // Word 1 gapped: one byte every 3 cycles, stray ack in FILL ignored
      for (int k = 0; k < 4; k++) begin
         put(8'hA0 + 8'(k), 2'(k));
         i_valid = 1'b0;
         i_word_ack = (k == 1);
         cyc();
         i_word_ack = 1'b0;
         chk("gap.wr1", 32'(o_wr), 0);
         cyc();
         chk("gap.wr2",  32'(o_wr), 0);
         chk("gap.byte", 32'(o_byte), 32'hA0 + 32'(k));
         chk("gap.idx",  32'(o_word_index), 1);
      end
      chk("w1.wv", 32'(o_word_valid), 1);
      i_word_ack = 1'b1;
      cyc();
      i_word_ack = 1'b0;
      chk("ack1.idx", 32'(o_word_index), 2);

      // Word 2: two bytes then asynchronous reset
      put(8'h55, 2'd0);
      put(8'h66, 2'd1);
      i_valid = 1'b0;
      #2 i_rst = 1'b1;
      #1 chk_all_zero("async_rst");
      #2 i_rst = 1'b0;

      // Full burst with immediate acks; start in FILL ignored on word 1
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("rs.idx", 32'(o_word_index), 0);
      chk("rs.rdy", 32'(o_ready), 1);
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < 4; b++) begin
            i_start = (w == 1 && b == 1);
            put(8'(w * 16 + b + 1), 2'(b));
            i_start = 1'b0;
         end
         i_valid = 1'b0;
         cyc();
         chk("burst.wv",  32'(o_word_valid), 1);
         chk("burst.idx", 32'(o_word_index), 32'(w));
         i_word_ack = 1'b1;
         cyc();
         i_word_ack = 1'b0;
         if (w < 3) begin
            chk("burst.nidx", 32'(o_word_index), 32'(w + 1));
            chk("burst.rdy",  32'(o_ready), 1);
         end
      end
      chk("done.done", 32'(o_done), 1);
      chk("done.rdy",  32'(o_ready), 0);
      chk("done.wv",   32'(o_word_valid), 0);
      chk("done.idx",  32'(o_word_index), 3);

      // DONE ignores traffic and acks
      i_valid = 1'b1; i_data = 8'h77; i_word_ack = 1'b1;
      cyc(); cyc();
      i_valid = 1'b0; i_word_ack = 1'b0;
      chk("idle_done.wr",   32'(o_wr), 0);
      chk("idle_done.done", 32'(o_done), 1);
      chk("idle_done.idx",  32'(o_word_index), 3);

      // Restart from DONE
      i_start = 1'b1;
      cyc();
      i_start = 1'b0;
      chk("restart.done", 32'(o_done), 0);
      chk("restart.idx",  32'(o_word_index), 0);
      chk("restart.rdy",  32'(o_ready), 1);
      for (int b = 0; b < 4; b++) put(8'hC0 + 8'(b), 2'(b));
      i_valid = 1'b0;
      cyc();
      chk("restart.wv", 32'(o_word_valid), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
